// File: rtl/i2c_cmd_sequencer.sv
// Command queue in front of i2c_master: buffers {rw, addr, wdata} entries and
// issues them one at a time over the enable/busy handshake, returning read bytes.
//
// state     | meaning
// IDLE      | waiting for a queued command, idle master and no pending read byte
// ISSUE     | m_enable held, waiting for m_busy or issue timeout
// WAIT_DONE | master running, waiting for m_busy to fall
// CAPTURE   | read byte registered; one gap cycle before the next issue
module i2c_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rw,
    input  logic [6:0]               cmd_addr,
    input  logic [7:0]               cmd_wdata,
    output logic [6:0]               m_addr,
    output logic [7:0]               m_data_in,
    output logic                     m_rw,
    output logic                     m_enable,
    input  logic                     m_busy,
    input  logic [7:0]               m_data_out,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic                     err_timeout,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     seq_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, CAPTURE} state_t;

    state_t          state, state_nx;
    logic [15:0]     fifo_mem [DEPTH];
    logic [15:0]     head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [TW-1:0]   timer;
    logic            push, pop, issue_end, timed_out, capture;

    assign cmd_ready  = (count < FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];
    assign fifo_count = count;
    assign seq_busy   = (count != '0) || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        issue_end = 1'b0;
        timed_out = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                // a pending read byte blocks issue so it can never be overwritten
                if ((count != '0) && !m_busy && !rd_valid) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (m_busy) begin
                    issue_end = 1'b1;
                    state_nx  = WAIT_DONE;
                end else if (timer == '0) begin
                    issue_end = 1'b1;
                    timed_out = 1'b1;
                    state_nx  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!m_busy) begin
                    if (m_rw) begin
                        capture  = 1'b1;
                        state_nx = CAPTURE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            CAPTURE:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // timer loads TIMEOUT-1 on issue and counts down; terminal count is zero
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_addr      <= '0;
            m_data_in   <= '0;
            m_rw        <= 1'b0;
            m_enable    <= 1'b0;
            timer       <= '0;
            err_timeout <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            err_timeout <= timed_out;
            if (pop) begin
                m_addr    <= head[14:8];
                m_data_in <= head[7:0];
                m_rw      <= head[15];
                m_enable  <= 1'b1;
                timer     <= TW'(TIMEOUT - 1);
            end else if (issue_end) begin
                m_enable  <= 1'b0;
            end else if (state == ISSUE) begin
                timer     <= timer - 1'b1;
            end
            if (capture) begin
                rd_data  <= m_data_out;
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: behavioural master on the negedge, single-command
// vector table plus directed sequences for ordering, back-pressure, fill, timeout, reset.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic       m_busy = 1'b0;
    logic [7:0] m_data_out = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       err_timeout;
    logic [2:0] fifo_count;
    logic       seq_busy;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
        .m_busy(m_busy), .m_data_out(m_data_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .err_timeout(err_timeout), .fifo_count(fifo_count), .seq_busy(seq_busy)
    );

    // master model: 0 = normal, 1 = ignores enable, 2 = busy stuck high
    int         mode = 0;
    int         busy_len = 3;
    int         mcnt = 0;
    logic [7:0] slave_rd = '0;
    logic [6:0] log_addr [64];
    logic       log_rw   [64];
    logic [7:0] log_wd   [64];
    int         log_n = 0;

    always @(negedge clk) begin
        if (areset) begin
            m_busy = 1'b0;
            mcnt = 0;
        end else if (mode == 2) begin
            m_busy = 1'b1;
            mcnt = 0;
        end else if (m_busy) begin
            if (mcnt == 0) begin
                m_busy = 1'b0;
                m_data_out = slave_rd;
            end else begin
                mcnt--;
            end
        end else if (m_enable && mode == 0) begin
            m_busy = 1'b1;
            mcnt = busy_len - 1;
            if (log_n < 64) begin
                log_addr[log_n] = m_addr;
                log_rw[log_n]   = m_rw;
                log_wd[log_n]   = m_data_in;
            end
            log_n++;
        end
    end

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] slv;
        logic       exp_rv;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [6:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((seq_busy || m_busy) && n < 200) begin
            tick();
            n++;
        end
        chk(nm, 32'(seq_busy || m_busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string pre);
        chk({pre, "_fifo_count"}, 32'(fifo_count), 32'd0);
        chk({pre, "_cmd_ready"},  32'(cmd_ready), 32'd1);
        chk({pre, "_m_enable"},   32'(m_enable), 32'd0);
        chk({pre, "_m_addr"},     32'(m_addr), 32'd0);
        chk({pre, "_m_data_in"},  32'(m_data_in), 32'd0);
        chk({pre, "_m_rw"},       32'(m_rw), 32'd0);
        chk({pre, "_rd_valid"},   32'(rd_valid), 32'd0);
        chk({pre, "_rd_data"},    32'(rd_data), 32'd0);
        chk({pre, "_err_timeout"},32'(err_timeout), 32'd0);
        chk({pre, "_seq_busy"},   32'(seq_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        int en_seen;
        logic [6:0] t3_addr [3];
        logic       t3_rw   [3];
        logic [7:0] t3_wd   [3];

        tbl[0] = '{rw: 1'b0, addr: 7'h57, wdata: 8'hAA, slv: 8'h00, exp_rv: 1'b0, exp_rd: 8'h00};
        tbl[1] = '{rw: 1'b1, addr: 7'h57, wdata: 8'h00, slv: 8'hCD, exp_rv: 1'b1, exp_rd: 8'hCD};
        tbl[2] = '{rw: 1'b0, addr: 7'h00, wdata: 8'hFF, slv: 8'h00, exp_rv: 1'b0, exp_rd: 8'h00};
        tbl[3] = '{rw: 1'b1, addr: 7'h7F, wdata: 8'h00, slv: 8'h3C, exp_rv: 1'b1, exp_rd: 8'h3C};

        // reset values
        repeat (3) tick();
        chk_reset_vals("rst");
        areset = 1'b0;
        tick();

        // single write: enable one cycle after push, drops after busy rises
        push(1'b0, 7'h57, 8'hAA);
        chk("t1_en_before", 32'(m_enable), 32'd0);
        chk("t1_count", 32'(fifo_count), 32'd1);
        chk("t1_seq_busy", 32'(seq_busy), 32'd1);
        tick();
        chk("t1_en_rise", 32'(m_enable), 32'd1);
        chk("t1_m_addr", 32'(m_addr), 32'h57);
        chk("t1_m_data_in", 32'(m_data_in), 32'hAA);
        chk("t1_m_rw", 32'(m_rw), 32'd0);
        chk("t1_count_pop", 32'(fifo_count), 32'd0);
        tick();
        chk("t1_en_drop", 32'(m_enable), 32'd0);
        wait_idle("t1_idle");
        chk("t1_rd_valid", 32'(rd_valid), 32'd0);

        // read: rd_valid one cycle after busy falls, held until accepted
        slave_rd = 8'hCD;
        push(1'b1, 7'h57, 8'h00);
        n = 0;
        while (!m_busy && n < 20) begin tick(); n++; end
        chk("t2_busy_rise", 32'(m_busy), 32'd1);
        n = 0;
        while (m_busy && n < 50) begin @(negedge clk); #1; n++; end
        chk("t2_busy_fall", 32'(m_busy), 32'd0);
        chk("t2_rv_early", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("t2_rv_lat", 32'(rd_valid), 32'd1);
        chk("t2_rd_data", 32'(rd_data), 32'hCD);
        repeat (5) tick();
        chk("t2_rv_hold", 32'(rd_valid), 32'd1);
        chk("t2_rd_hold", 32'(rd_data), 32'hCD);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t2_rv_clear", 32'(rd_valid), 32'd0);

        // table of single commands
        for (int i = 0; i < 4; i++) begin
            n0 = log_n;
            slave_rd = tbl[i].slv;
            push(tbl[i].rw, tbl[i].addr, tbl[i].wdata);
            wait_idle($sformatf("tbl%0d_idle", i));
            chk($sformatf("tbl%0d_log_n", i), 32'(log_n), 32'(n0 + 1));
            chk($sformatf("tbl%0d_addr", i), 32'(log_addr[n0]), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_rw", i), 32'(log_rw[n0]), 32'(tbl[i].rw));
            if (!tbl[i].rw)
                chk($sformatf("tbl%0d_wd", i), 32'(log_wd[n0]), 32'(tbl[i].wdata));
            chk($sformatf("tbl%0d_m_addr_hold", i), 32'(m_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_rv", i), 32'(rd_valid), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv)
                chk($sformatf("tbl%0d_rd", i), 32'(rd_data), 32'(tbl[i].exp_rd));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end

        // back-to-back pushes with read back-pressure
        t3_addr[0] = 7'h10; t3_rw[0] = 1'b0; t3_wd[0] = 8'h11;
        t3_addr[1] = 7'h20; t3_rw[1] = 1'b1; t3_wd[1] = 8'h00;
        t3_addr[2] = 7'h30; t3_rw[2] = 1'b0; t3_wd[2] = 8'h22;
        slave_rd = 8'h5A;
        n0 = log_n;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_cmd_ready%0d", i), 32'(cmd_ready), 32'd1);
            push(t3_rw[i], t3_addr[i], t3_wd[i]);
        end
        repeat (40) tick();
        chk("t3_held_log_n", 32'(log_n), 32'(n0 + 2));
        chk("t3_rv", 32'(rd_valid), 32'd1);
        chk("t3_rd", 32'(rd_data), 32'h5A);
        chk("t3_count", 32'(fifo_count), 32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        wait_idle("t3_idle");
        chk("t3_log_n", 32'(log_n), 32'(n0 + 3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_addr%0d", i), 32'(log_addr[n0 + i]), 32'(t3_addr[i]));
            chk($sformatf("t3_rw%0d", i), 32'(log_rw[n0 + i]), 32'(t3_rw[i]));
            if (!t3_rw[i])
                chk($sformatf("t3_wd%0d", i), 32'(log_wd[n0 + i]), 32'(t3_wd[i]));
        end

        // fill FIFO with master stuck busy, extra push ignored, then drain
        mode = 2;
        repeat (2) tick();
        for (int i = 0; i < DEPTH; i++)
            push(1'b0, 7'(7'h41 + i), 8'(8'h41 + i));
        chk("t4_full_count", 32'(fifo_count), 32'(DEPTH));
        chk("t4_full_ready", 32'(cmd_ready), 32'd0);
        push(1'b0, 7'h55, 8'h55);
        chk("t4_overflow_count", 32'(fifo_count), 32'(DEPTH));
        n0 = log_n;
        mode = 0;
        wait_idle("t4_idle");
        chk("t4_log_n", 32'(log_n), 32'(n0 + DEPTH));
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("t4_wd%0d", i), 32'(log_wd[n0 + i]), 32'(8'h41 + i));

        // issue timeout: enable high exactly TIMEOUT cycles, then next command issues
        mode = 1;
        n0 = log_n;
        push(1'b0, 7'h11, 8'h77);
        push(1'b0, 7'h22, 8'h88);
        n = 0;
        while (!m_enable && n < 10) begin tick(); n++; end
        n = 0;
        while (m_enable && n < 40) begin n++; tick(); end
        chk("t5_en_cycles", 32'(n), 32'(TIMEOUT));
        chk("t5_err_pulse", 32'(err_timeout), 32'd1);
        mode = 0;
        tick();
        chk("t5_err_clear", 32'(err_timeout), 32'd0);
        chk("t5_next_en", 32'(m_enable), 32'd1);
        chk("t5_next_addr", 32'(m_addr), 32'h22);
        wait_idle("t5_idle");
        chk("t5_log_n", 32'(log_n), 32'(n0 + 1));
        chk("t5_log_addr", 32'(log_addr[n0]), 32'h22);
        chk("t5_log_wd", 32'(log_wd[n0]), 32'h88);

        // reset during WAIT_DONE with two entries queued
        busy_len = 8;
        push(1'b0, 7'h61, 8'h61);
        push(1'b0, 7'h62, 8'h62);
        push(1'b0, 7'h63, 8'h63);
        tick();
        chk("t6_pre_count", 32'(fifo_count), 32'd2);
        chk("t6_pre_busy", 32'(m_busy), 32'd1);
        #2;
        areset = 1'b1;
        #1;
        chk_reset_vals("t6");
        tick();
        tick();
        areset = 1'b0;
        busy_len = 3;
        n0 = log_n;
        en_seen = 0;
        repeat (20) begin
            tick();
            if (m_enable) en_seen++;
        end
        chk("t6_no_issue", 32'(en_seen), 32'd0);
        chk("t6_log_n", 32'(log_n), 32'(n0));
        chk("t6_count", 32'(fifo_count), 32'd0);
        push(1'b0, 7'h0F, 8'hF0);
        wait_idle("t6_idle");
        chk("t6_new_log_n", 32'(log_n), 32'(n0 + 1));
        chk("t6_new_addr", 32'(log_addr[n0]), 32'h0F);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
